// File: rtl/mmio_tx_fifo.sv
// mmio_tx_fifo: CPU-writable transmit FIFO on the p18240 memory bus.
// Stores push words, loads poll status, a consumer drains via valid/ready.
module mmio_tx_fifo #(
  parameter int          DEPTH     = 8,
  parameter logic [15:0] BASE_ADDR = 16'h2002
) (
  input  logic        clock,
  input  logic        reset_L,
  input  logic [15:0] memAddr,
  inout  wire  [15:0] dataBus,
  input  logic        re_L,
  input  logic        we_L,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  count
);

  localparam int PW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_C =
    4'(DEPTH);
  localparam logic [15:0] STAT_ADDR =
    BASE_ADDR + 16'd2;

  logic [15:0]   mem_q [DEPTH];
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [3:0]    count_q, count_d;
  logic          ovf_q, ovf_d;

  logic        hit_data, hit_stat;
  logic        wr, push_req, push, pop;
  logic        flush, clr;
  logic        empty, full, rd_en;
  logic [15:0] status, rd_data;

  assign hit_data = (memAddr == BASE_ADDR);
  assign hit_stat = (memAddr == STAT_ADDR);
  assign wr       = ~we_L;

  assign empty     = (count_q == 4'd0);
  assign full      = (count_q == DEPTH_C);
  assign out_valid = ~empty;
  assign out_data  = empty ? 16'h0000
                           : mem_q[rptr_q];
  assign count     = count_q;

  assign pop      = out_valid & out_ready;
  assign flush    = wr & hit_stat & dataBus[1];
  assign clr      = wr & hit_stat & dataBus[0];
  assign push_req = wr & hit_data;
  // a pop on the same edge frees a slot
  assign push     = push_req & ~flush
                  & (~full | pop);

  assign status = {8'h00, count_q, 1'b0,
                   ovf_q, full, empty};

  // loads are side-effect free; a
  // simultaneous write strobe wins
  assign rd_en   = ~re_L & we_L
                 & (hit_data | hit_stat);
  assign rd_data = hit_data ? out_data
                            : status;
  assign dataBus = rd_en ? rd_data
                         : 16'hzzzz;

  // next-state for pointers, occupancy
  // and the sticky overflow flag
  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = 4'd0;
    end else begin
      if (pop)
        rptr_d = rptr_q + PW'(1);
      if (push)
        wptr_d = wptr_q + PW'(1);
      if (push && !pop)
        count_d = count_q + 4'd1;
      else if (pop && !push)
        count_d = count_q - 4'd1;
    end
    if (clr)
      ovf_d = 1'b0;
    if (push_req && full && !pop && !flush)
      ovf_d = 1'b1;
  end

  // control state register, sync reset
  always_ff @(posedge clock) begin
    if (!reset_L) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= 4'd0;
      ovf_q   <= 1'b0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // storage array, intentionally unreset
  always_ff @(posedge clock) begin
    if (reset_L && push)
      mem_q[wptr_q] <= dataBus;
  end

endmodule

// File: tb/tb_mmio_tx_fifo.sv
// tb_mmio_tx_fifo: directed + random bench
// against a queue-based reference model.
module tb_mmio_tx_fifo;

  localparam int DEPTH = 8;
  localparam logic [15:0] DATA_A = 16'h2002;
  localparam logic [15:0] STAT_A = 16'h2004;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic        re_n = 1'b1;
  logic        we_n = 1'b1;
  logic        ready = 1'b0;
  logic        tb_en = 1'b0;
  logic [15:0] tb_val = 16'h0000;
  wire  [15:0] dataBus;
  logic [15:0] out_data;
  logic        out_valid;
  logic [3:0]  count;

  int errors = 0;
  int checks = 0;

  logic [15:0] mq [$];
  bit          movf = 1'b0;

  assign dataBus = tb_en ? tb_val : 16'hzzzz;

  mmio_tx_fifo dut (
    .clock    (clock),
    .reset_L  (rst_n),
    .memAddr  (addr),
    .dataBus  (dataBus),
    .re_L     (re_n),
    .we_L     (we_n),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(ready),
    .count    (count)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL timeout obs=running exp=done");
    $fatal(1, "timeout");
  end

  task automatic chk(string tag,
                     logic [15:0] obs,
                     logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_stat();
    logic [15:0] s;
    s = 16'h0000;
    s[7:4] = 4'(mq.size());
    s[2] = movf;
    s[1] = (mq.size() == DEPTH);
    s[0] = (mq.size() == 0);
    return s;
  endfunction

  function automatic logic [15:0] m_head();
    return (mq.size() != 0) ? mq[0] : 16'h0000;
  endfunction

  // apply the edge to the model, clock the
  // DUT, then compare consumer-side outputs
  task automatic cyc();
    bit pop;
    pop = (mq.size() != 0) && ready;
    if (!rst_n) begin
      mq.delete();
      movf = 1'b0;
    end else if (!we_n && addr == STAT_A) begin
      if (tb_val[1]) mq.delete();
      else if (pop) void'(mq.pop_front());
      if (tb_val[0]) movf = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (!we_n && addr == DATA_A) begin
        if (mq.size() < DEPTH)
          mq.push_back(tb_val);
        else
          movf = 1'b1;
      end
    end
    @(posedge clock);
    #1;
    chk("count", 16'(count), 16'(mq.size()));
    chk("valid", 16'(out_valid),
        16'(mq.size() != 0));
    chk("data", out_data, m_head());
  endtask

  task automatic store(logic [15:0] a,
                       logic [15:0] v);
    addr = a;
    re_n = 1'b1;
    we_n = 1'b0;
    tb_en = 1'b1;
    tb_val = v;
    cyc();
    we_n = 1'b1;
    tb_en = 1'b0;
  endtask

  task automatic load(logic [15:0] a,
                      logic [15:0] exp,
                      string tag);
    addr = a;
    we_n = 1'b1;
    tb_en = 1'b0;
    re_n = 1'b0;
    #1;
    chk(tag, dataBus, exp);
    re_n = 1'b1;
    #1;
  endtask

  // bench drives 0; any DUT drive shows
  task automatic no_drive(logic [15:0] a,
                          string tag);
    addr = a;
    we_n = 1'b1;
    tb_en = 1'b1;
    tb_val = 16'h0000;
    re_n = 1'b0;
    #1;
    chk(tag, dataBus, 16'h0000);
    re_n = 1'b1;
    tb_en = 1'b0;
    #1;
  endtask

  initial begin
    int op;
    @(negedge clock);
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    load(STAT_A, 16'h0001, "rst_stat");
    chk("rst_cnt", 16'(count), 16'd0);
    chk("rst_data", out_data, 16'h0000);
    no_drive(16'h2010, "miss_z0");

    ready = 1'b0;
    store(DATA_A, 16'hA5A5);
    store(DATA_A, 16'h1234);
    chk("two_cnt", 16'(count), 16'd2);
    chk("two_head", out_data, 16'hA5A5);
    load(DATA_A, 16'hA5A5, "rd_head");
    chk("rd_nopop", 16'(count), 16'd2);
    load(STAT_A, 16'h0020, "two_stat");
    no_drive(16'h2010, "miss_z1");
    no_drive(16'h2003, "miss_z2");
    no_drive(16'h2000, "miss_z3");
    store(STAT_A, 16'h0002);

    for (int i = 0; i < 8; i++)
      store(DATA_A, 16'(i));
    store(DATA_A, 16'hDEAD);
    load(STAT_A, 16'h0086, "ovf_stat");
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain", out_data, 16'(i));
      cyc();
    end
    ready = 1'b0;
    chk("drain_end", 16'(out_valid), 16'd0);
    store(STAT_A, 16'h0001);
    load(STAT_A, 16'h0001, "clr_stat");

    for (int i = 0; i < 8; i++)
      store(DATA_A, 16'h0010 + 16'(i));
    ready = 1'b1;
    store(DATA_A, 16'hBEEF);
    chk("pp_cnt", 16'(count), 16'd8);
    ready = 1'b0;
    load(STAT_A, 16'h0082, "pp_stat");
    ready = 1'b1;
    for (int i = 0; i < 7; i++)
      cyc();
    chk("beef_last", out_data, 16'hBEEF);
    cyc();
    ready = 1'b0;

    for (int i = 0; i < 5; i++)
      store(DATA_A, 16'h0100 + 16'(i));
    store(STAT_A, 16'h0002);
    chk("flush_cnt", 16'(count), 16'd0);
    chk("flush_vld", 16'(out_valid), 16'd0);
    ready = 1'b1;
    for (int i = 0; i < 20; i++)
      store(DATA_A, 16'h0200 + 16'(i));
    cyc();
    ready = 1'b0;

    for (int i = 0; i < 3; i++)
      store(DATA_A, 16'h0300 + 16'(i));
    rst_n = 1'b0;
    store(DATA_A, 16'h0399);
    rst_n = 1'b1;
    chk("rst2_cnt", 16'(count), 16'd0);
    chk("rst2_vld", 16'(out_valid), 16'd0);
    load(STAT_A, 16'h0001, "rst2_stat");

    for (int i = 0; i < 400; i++) begin
      ready = 1'($urandom_range(0, 1));
      op = int'($urandom_range(0, 11));
      if (op <= 5)
        store(DATA_A, 16'($urandom));
      else if (op == 6 &&
               $urandom_range(0, 5) == 0)
        store(STAT_A,
              16'($urandom_range(0, 3)));
      else if (op == 7)
        load(DATA_A, m_head(), "r_data");
      else if (op == 8)
        load(STAT_A, m_stat(), "r_stat");
      else if (op == 9)
        no_drive(16'($urandom), "r_miss");
      else
        cyc();
    end
    load(STAT_A, m_stat(), "fin_stat");

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
